// File: rtl/pingpong_buf_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_buf_ctrl
// Sequences two DEPTH-entry RGB line buffers as a ping-pong pair: the pixel
// source fills one buffer while the display side drains the other.
//
// Ports
//   Clock, Reset          : system clock, asynchronous active-high reset
//   PixIn/PixInValid      : source pixel and its valid strobe
//   PixInReady            : controller accepts PixIn this cycle
//   PixOutReq             : display requests the next pixel
//   PixOutValid/PixOutSel : requested pixel present on the selected buffer output
//   Underrun              : one-cycle pulse, request arrived with no full buffer
//   BufferIn              : write data shared by both buffers
//   Addr1/WE1/RE1         : Buffer1 control
//   Addr2/WE2/RE2         : Buffer2 control
//   UnderrunCount         : saturating underrun counter (only with UNDERRUN_CNT_EN)
//
// Optional feature macro: UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module pingpong_buf_ctrl #(
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [23:0]       PixIn,
    input  logic              PixInValid,
    output logic              PixInReady,
    input  logic              PixOutReq,
    output logic              PixOutValid,
    output logic              PixOutSel,
    output logic              Underrun,
    output logic [23:0]       BufferIn,
    output logic [ADDR_W-1:0] Addr1,
    output logic              WE1,
    output logic              RE1,
    output logic [ADDR_W-1:0] Addr2,
    output logic              WE2,
    output logic              RE2
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]       UnderrunCount
`endif
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    // Pointer/flag state
    logic              wbuf_q, wbuf_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [1:0]        full_q, full_d;

    // Registered buffer-side outputs
    logic              we1_q, we1_d, we2_q, we2_d;
    logic              re1_q, re1_d, re2_q, re2_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [23:0]       buf_in_q, buf_in_d;

    // Read pipeline: stage 1 marks RE cycle, stage 2 is the data-valid cycle
    logic              rd_pend_q, rd_pend_d;
    logic              rd_sel_q, rd_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sel_q, out_sel_d;
    logic              underrun_q, underrun_d;

    logic              accept_s;
    logic              issue_s;

    assign PixInReady = ~full_q[wbuf_q];
    assign accept_s   = PixInValid & ~full_q[wbuf_q];
    assign issue_s    = PixOutReq & full_q[rbuf_q];

    // Next-state for pointers, flags and registered outputs
    always_comb begin
        wbuf_d      = wbuf_q;
        wptr_d      = wptr_q;
        rbuf_d      = rbuf_q;
        rptr_d      = rptr_q;
        full_d      = full_q;
        we1_d       = 1'b0;
        we2_d       = 1'b0;
        re1_d       = 1'b0;
        re2_d       = 1'b0;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        buf_in_d    = buf_in_q;
        rd_pend_d   = issue_s;
        rd_sel_d    = rd_sel_q;
        out_valid_d = rd_pend_q;
        out_sel_d   = out_sel_q;
        underrun_d  = PixOutReq & ~full_q[rbuf_q];

        if (accept_s) begin
            buf_in_d = PixIn;
            if (wbuf_q) begin
                we2_d   = 1'b1;
                addr2_d = wptr_q;
            end else begin
                we1_d   = 1'b1;
                addr1_d = wptr_q;
            end
            if (wptr_q == PTR_LAST) begin
                full_d[wbuf_q] = 1'b1;
                wbuf_d         = ~wbuf_q;
                wptr_d         = PTR_ZERO;
            end else begin
                wptr_d = wptr_q + PTR_ONE;
            end
        end else begin
            wptr_d = wptr_q;
        end

        // A read always targets the other buffer than a same-cycle write,
        // so the address updates below never collide with the ones above.
        if (issue_s) begin
            rd_sel_d = rbuf_q;
            if (rbuf_q) begin
                re2_d   = 1'b1;
                addr2_d = rptr_q;
            end else begin
                re1_d   = 1'b1;
                addr1_d = rptr_q;
            end
            if (rptr_q == PTR_LAST) begin
                full_d[rbuf_q] = 1'b0;
                rbuf_d         = ~rbuf_q;
                rptr_d         = PTR_ZERO;
            end else begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end else begin
            rptr_d = rptr_q;
        end

        if (rd_pend_q) begin
            out_sel_d = rd_sel_q;
        end else begin
            out_sel_d = out_sel_q;
        end
    end

    // State and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wbuf_q      <= 1'b0;
            wptr_q      <= PTR_ZERO;
            rbuf_q      <= 1'b0;
            rptr_q      <= PTR_ZERO;
            full_q      <= 2'b00;
            we1_q       <= 1'b0;
            we2_q       <= 1'b0;
            re1_q       <= 1'b0;
            re2_q       <= 1'b0;
            addr1_q     <= PTR_ZERO;
            addr2_q     <= PTR_ZERO;
            buf_in_q    <= 24'h000000;
            rd_pend_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wbuf_q      <= wbuf_d;
            wptr_q      <= wptr_d;
            rbuf_q      <= rbuf_d;
            rptr_q      <= rptr_d;
            full_q      <= full_d;
            we1_q       <= we1_d;
            we2_q       <= we2_d;
            re1_q       <= re1_d;
            re2_q       <= re2_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            buf_in_q    <= buf_in_d;
            rd_pend_q   <= rd_pend_d;
            rd_sel_q    <= rd_sel_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            underrun_q  <= underrun_d;
        end
    end

    assign WE1         = we1_q;
    assign WE2         = we2_q;
    assign RE1         = re1_q;
    assign RE2         = re2_q;
    assign Addr1       = addr1_q;
    assign Addr2       = addr2_q;
    assign BufferIn    = buf_in_q;
    assign PixOutValid = out_valid_q;
    assign PixOutSel   = out_sel_q;
    assign Underrun    = underrun_q;

`ifdef UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Counter steps on the same edge that raises Underrun, so both agree
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Underrun counter register, cleared only by Reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ucnt_q <= 16'h0000;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign UnderrunCount = ucnt_q;
`endif

endmodule
